ctrl_issue_unit: RTL and testbench

//  Parametrised ID/EX control stage for the pipelined RISC-V core. Decodes the

---
 rtl/ctrl_issue_unit_if.sv | 46 ++++
 rtl/ctrl_issue_unit.sv | 125 ++++++++++++
 tb/tb_ctrl_issue_unit.sv | 189 ++++++++++++++++++
 3 files changed

// File: rtl/ctrl_issue_unit_if.sv
// ctrl_issue_unit_if
//  Bundles the ID-side request and the registered ID/EX control outputs of
//  ctrl_issue_unit.
//  master : the upstream decode/hazard logic. It drives valid/op/funct7/stall/flush
//           and observes busy and the EX bundle.
//  slave  : ctrl_issue_unit itself.
//  Signals:
//   valid_i, op_i, funct7_i  instruction presented by ID
//   stall_i, flush_i         hazard-unit bubble request / branch flush
//   busy_o                   mul/div in progress, hold IF/ID
//   ex_*_o                   registered EX/MEM/WB control bundle
interface ctrl_issue_unit_if #(
  parameter int OP_W    = 7,
  parameter int ALUOP_W = 2
);
  logic               valid_i;
  logic [OP_W-1:0]    op_i;
  logic [6:0]         funct7_i;
  logic               stall_i;
  logic               flush_i;
  logic               busy_o;
  logic               ex_valid_o;
  logic [ALUOP_W-1:0] ex_alu_op_o;
  logic               ex_alu_src_o;
  logic               ex_reg_write_o;
  logic               ex_mem_to_reg_o;
  logic               ex_mem_read_o;
  logic               ex_mem_write_o;
  logic               ex_branch_o;
  logic               ex_muldiv_o;
  logic               ex_illegal_o;

  modport master (
    output valid_i, op_i, funct7_i, stall_i, flush_i,
    input  busy_o, ex_valid_o, ex_alu_op_o, ex_alu_src_o, ex_reg_write_o,
           ex_mem_to_reg_o, ex_mem_read_o, ex_mem_write_o, ex_branch_o,
           ex_muldiv_o, ex_illegal_o
  );

  modport slave (
    input  valid_i, op_i, funct7_i, stall_i, flush_i,
    output busy_o, ex_valid_o, ex_alu_op_o, ex_alu_src_o, ex_reg_write_o,
           ex_mem_to_reg_o, ex_mem_read_o, ex_mem_write_o, ex_branch_o,
           ex_muldiv_o, ex_illegal_o
  );
endinterface

// File: rtl/ctrl_issue_unit.sv
// ctrl_issue_unit
//  ID/EX control stage. Decodes the opcode (and funct7 for M-extension ops) into
//  the EX/MEM/WB control bundle and registers it at the ID/EX boundary. It
//  injects bubbles on stall, flush and illegal opcodes. It holds EX for
//  MULDIV_LAT cycles on a mul/div and raises busy_o for the extra cycles.
//  Ports:
//   clk_i  rising-edge clock
//   rst_i  synchronous active-high reset
//   bus    ctrl_issue_unit_if.slave (ID request in, EX bundle and busy out)
module ctrl_issue_unit #(
  parameter int OP_W       = 7,
  parameter int ALUOP_W    = 2,
  parameter int MULDIV_EN  = 1,
  parameter int MULDIV_LAT = 4
) (
  input  logic                clk_i,
  input  logic                rst_i,
  ctrl_issue_unit_if.slave    bus
);

  localparam int CNT_W = $clog2(MULDIV_LAT) + 1;
  localparam logic [CNT_W-1:0] CNT_LOAD = CNT_W'(MULDIV_LAT - 1);
  localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

  localparam logic [OP_W-1:0] OPC_R  = OP_W'(7'b0110011);
  localparam logic [OP_W-1:0] OPC_I  = OP_W'(7'b0010011);
  localparam logic [OP_W-1:0] OPC_LD = OP_W'(7'b0000011);
  localparam logic [OP_W-1:0] OPC_ST = OP_W'(7'b0100011);
  localparam logic [OP_W-1:0] OPC_BR = OP_W'(7'b1100011);

  typedef struct packed {
    logic               valid;
    logic [ALUOP_W-1:0] alu_op;
    logic               alu_src;
    logic               reg_write;
    logic               mem_to_reg;
    logic               mem_read;
    logic               mem_write;
    logic               branch;
    logic               muldiv;
    logic               illegal;
  } bundle_t;

  bundle_t          dec;
  bundle_t          ex_q;
  logic [CNT_W-1:0] cnt_q;
  logic             busy;

  // Unknown opcodes leave every field at zero except illegal, so the
  // instruction enters EX as a flagged bubble.
  always_comb begin
    dec       = '0;
    dec.valid = 1'b1;
    case (bus.op_i)
      OPC_R: begin
        dec.alu_op    = ALUOP_W'(2'b11);
        dec.reg_write = 1'b1;
        dec.muldiv    = (MULDIV_EN != 0) && (bus.funct7_i == 7'b0000001);
      end
      OPC_I: begin
        dec.alu_op    = ALUOP_W'(2'b01);
        dec.alu_src   = 1'b1;
        dec.reg_write = 1'b1;
      end
      OPC_LD: begin
        dec.alu_src    = 1'b1;
        dec.reg_write  = 1'b1;
        dec.mem_to_reg = 1'b1;
        dec.mem_read   = 1'b1;
      end
      OPC_ST: begin
        dec.alu_op    = ALUOP_W'(2'b10);
        dec.alu_src   = 1'b1;
        dec.mem_write = 1'b1;
      end
      OPC_BR: begin
        dec.alu_op = ALUOP_W'(2'b10);
        dec.branch = 1'b1;
      end
      default: begin
        dec.valid   = 1'b0;
        dec.illegal = 1'b1;
      end
    endcase
  end

  assign busy = (cnt_q != '0);

  // Priority: reset, flush, mul/div hold, stall, accept, idle bubble.
  // While busy the counter only counts down, so it cannot wrap below zero.
  // With MULDIV_LAT=1 the load value is zero and busy never rises.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      ex_q  <= '0;
      cnt_q <= '0;
    end else if (bus.flush_i) begin
      ex_q  <= '0;
      cnt_q <= '0;
    end else if (busy) begin
      cnt_q <= cnt_q - CNT_ONE;
    end else if (bus.stall_i) begin
      ex_q <= '0;
    end else if (bus.valid_i) begin
      ex_q <= dec;
      if (dec.muldiv) begin
        cnt_q <= CNT_LOAD;
      end
    end else begin
      ex_q <= '0;
    end
  end

  assign bus.busy_o          = busy;
  assign bus.ex_valid_o      = ex_q.valid;
  assign bus.ex_alu_op_o     = ex_q.alu_op;
  assign bus.ex_alu_src_o    = ex_q.alu_src;
  assign bus.ex_reg_write_o  = ex_q.reg_write;
  assign bus.ex_mem_to_reg_o = ex_q.mem_to_reg;
  assign bus.ex_mem_read_o   = ex_q.mem_read;
  assign bus.ex_mem_write_o  = ex_q.mem_write;
  assign bus.ex_branch_o     = ex_q.branch;
  assign bus.ex_muldiv_o     = ex_q.muldiv;
  assign bus.ex_illegal_o    = ex_q.illegal;

endmodule

// File: tb/tb_ctrl_issue_unit.sv
// tb_ctrl_issue_unit
//  Directed scoreboard bench for ctrl_issue_unit. dut_a uses the default
//  parameters (mul/div enabled, latency 4). dut_b has mul/div disabled.
//  Each stimulus cycle pushes its hand-computed expected EX state and busy
//  value into a queue, tagged with the cycle in which it must appear. A
//  separate monitor pops and compares on the falling edge.
module tb_ctrl_issue_unit;

  typedef struct packed {
    logic       busy;
    logic       illegal;
    logic       muldiv;
    logic       br;
    logic       mwr;
    logic       mrd;
    logic       m2r;
    logic       rw;
    logic       src;
    logic [1:0] alu_op;
    logic       valid;
  } exp_t;

  logic clk;
  logic rst;
  int   cyc;
  int   n_checks;
  int   n_fail;

  int    due_q[$];
  exp_t  exp_q[$];
  bit    sel_q[$];
  string name_q[$];

  ctrl_issue_unit_if #(.OP_W(7), .ALUOP_W(2)) bus_a ();
  ctrl_issue_unit_if #(.OP_W(7), .ALUOP_W(2)) bus_b ();

  ctrl_issue_unit #(.OP_W(7), .ALUOP_W(2), .MULDIV_EN(1), .MULDIV_LAT(4)) dut_a (
    .clk_i (clk),
    .rst_i (rst),
    .bus   (bus_a.slave)
  );

  ctrl_issue_unit #(.OP_W(7), .ALUOP_W(2), .MULDIV_EN(0), .MULDIV_LAT(4)) dut_b (
    .clk_i (clk),
    .rst_i (rst),
    .bus   (bus_b.slave)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  always @(posedge clk) cyc <= cyc + 1;

  function automatic exp_t mk(input logic v, input logic [1:0] a, input logic s,
                              input logic w, input logic m2r, input logic rd,
                              input logic wr, input logic br, input logic md,
                              input logic il, input logic bz);
    exp_t e;
    e.valid = v;  e.alu_op = a; e.src = s; e.rw = w; e.m2r = m2r;
    e.mrd = rd;   e.mwr = wr;   e.br = br; e.muldiv = md;
    e.illegal = il; e.busy = bz;
    return e;
  endfunction

  function automatic exp_t sample(input bit sel);
    exp_t e;
    if (sel) begin
      e = {bus_b.busy_o, bus_b.ex_illegal_o, bus_b.ex_muldiv_o, bus_b.ex_branch_o,
           bus_b.ex_mem_write_o, bus_b.ex_mem_read_o, bus_b.ex_mem_to_reg_o,
           bus_b.ex_reg_write_o, bus_b.ex_alu_src_o, bus_b.ex_alu_op_o, bus_b.ex_valid_o};
    end else begin
      e = {bus_a.busy_o, bus_a.ex_illegal_o, bus_a.ex_muldiv_o, bus_a.ex_branch_o,
           bus_a.ex_mem_write_o, bus_a.ex_mem_read_o, bus_a.ex_mem_to_reg_o,
           bus_a.ex_reg_write_o, bus_a.ex_alu_src_o, bus_a.ex_alu_op_o, bus_a.ex_valid_o};
    end
    return e;
  endfunction

  task automatic checkOutput(input string name, input exp_t act, input exp_t exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("[TB] FAIL %s: got %b required %b (busy,ill,md,br,mwr,mrd,m2r,rw,src,aluop,valid)",
               name, act, exp);
    end
  endtask

  // Monitor: compare every expectation that falls due in the current cycle.
  always @(negedge clk) begin
    while (due_q.size() > 0 && due_q[0] == cyc) begin
      checkOutput(name_q[0], sample(sel_q[0]), exp_q[0]);
      void'(due_q.pop_front());
      void'(exp_q.pop_front());
      void'(sel_q.pop_front());
      void'(name_q.pop_front());
    end
  end

  // Drives one cycle of inputs to the selected DUT (the other idles) and
  // queues the state expected right after the next rising edge.
  task automatic applyStimulus(input bit sel, input logic r, input logic v,
                               input logic [6:0] op, input logic [6:0] f7,
                               input logic st, input logic fl,
                               input exp_t exp, input string name);
    @(posedge clk);
    #1;
    rst = r;
    bus_a.valid_i = sel ? 1'b0 : v;  bus_a.op_i = sel ? 7'd0 : op;
    bus_a.funct7_i = sel ? 7'd0 : f7;
    bus_a.stall_i = sel ? 1'b0 : st; bus_a.flush_i = sel ? 1'b0 : fl;
    bus_b.valid_i = sel ? v : 1'b0;  bus_b.op_i = sel ? op : 7'd0;
    bus_b.funct7_i = sel ? f7 : 7'd0;
    bus_b.stall_i = sel ? st : 1'b0; bus_b.flush_i = sel ? fl : 1'b0;
    due_q.push_back(cyc + 1);
    exp_q.push_back(exp);
    sel_q.push_back(sel);
    name_q.push_back(name);
  endtask

  localparam logic [6:0] R  = 7'b0110011;
  localparam logic [6:0] I  = 7'b0010011;
  localparam logic [6:0] LD = 7'b0000011;
  localparam logic [6:0] ST = 7'b0100011;
  localparam logic [6:0] BR = 7'b1100011;
  localparam logic [6:0] BAD = 7'b1111111;
  localparam logic [6:0] M7 = 7'b0000001;

  initial begin
    exp_t bub, r_b, ld_b, st_b, i_b, br_b, ill_b, mul_b, mul_busy;
    cyc = 0; n_checks = 0; n_fail = 0;
    rst = 1'b1;
    bus_a.valid_i = 1'b0; bus_a.op_i = '0; bus_a.funct7_i = '0;
    bus_a.stall_i = 1'b0; bus_a.flush_i = 1'b0;
    bus_b.valid_i = 1'b0; bus_b.op_i = '0; bus_b.funct7_i = '0;
    bus_b.stall_i = 1'b0; bus_b.flush_i = 1'b0;

    bub      = mk(0, 2'b00, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    r_b      = mk(1, 2'b11, 0, 1, 0, 0, 0, 0, 0, 0, 0);
    i_b      = mk(1, 2'b01, 1, 1, 0, 0, 0, 0, 0, 0, 0);
    ld_b     = mk(1, 2'b00, 1, 1, 1, 1, 0, 0, 0, 0, 0);
    st_b     = mk(1, 2'b10, 1, 0, 0, 0, 1, 0, 0, 0, 0);
    br_b     = mk(1, 2'b10, 0, 0, 0, 0, 0, 1, 0, 0, 0);
    ill_b    = mk(0, 2'b00, 0, 0, 0, 0, 0, 0, 0, 1, 0);
    mul_busy = mk(1, 2'b11, 0, 1, 0, 0, 0, 0, 1, 0, 1);
    mul_b    = mk(1, 2'b11, 0, 1, 0, 0, 0, 0, 1, 0, 0);

    //            sel rst v  op   f7  st fl  expected   name
    applyStimulus(0, 1, 0, 7'd0, 7'd0, 0, 0, bub,      "reset_0");
    applyStimulus(0, 1, 0, 7'd0, 7'd0, 0, 0, bub,      "reset_1");
    applyStimulus(0, 0, 1, R,    7'd0, 0, 0, r_b,      "r_type");
    applyStimulus(0, 0, 1, LD,   7'd0, 0, 0, ld_b,     "load");
    applyStimulus(0, 0, 1, ST,   7'd0, 0, 0, st_b,     "store_b2b");
    applyStimulus(0, 0, 1, R,    M7,   0, 0, mul_busy, "mul_c1");
    applyStimulus(0, 0, 1, I,    7'd0, 0, 0, mul_busy, "mul_c2_ignore_op");
    applyStimulus(0, 0, 1, I,    7'd0, 1, 0, mul_busy, "mul_c3_ignore_stall");
    applyStimulus(0, 0, 1, I,    7'd0, 0, 0, mul_b,    "mul_c4_busy_low");
    applyStimulus(0, 0, 1, I,    7'd0, 0, 0, i_b,      "accept_after_mul");
    applyStimulus(0, 0, 1, R,    M7,   0, 0, mul_busy, "mul2_c1");
    applyStimulus(0, 0, 1, I,    7'd0, 0, 0, mul_busy, "mul2_c2");
    applyStimulus(0, 0, 1, I,    7'd0, 0, 1, bub,      "flush_mid_mul");
    applyStimulus(0, 0, 1, ST,   7'd0, 1, 0, bub,      "stall_store");
    applyStimulus(0, 0, 1, ST,   7'd0, 0, 0, st_b,     "store_after_stall");
    applyStimulus(0, 0, 1, BAD,  7'd0, 0, 0, ill_b,    "illegal_op");
    applyStimulus(0, 0, 0, 7'd0, 7'd0, 0, 0, bub,      "idle_bubble");
    applyStimulus(0, 0, 1, R,    M7,   0, 0, mul_busy, "mul3_c1");
    applyStimulus(0, 0, 1, I,    7'd0, 0, 0, mul_busy, "mul3_c2");
    applyStimulus(0, 1, 1, I,    7'd0, 0, 0, bub,      "reset_mid_mul_0");
    applyStimulus(0, 1, 1, I,    7'd0, 0, 0, bub,      "reset_mid_mul_1");
    applyStimulus(0, 0, 0, 7'd0, 7'd0, 0, 0, bub,      "after_reset");
    applyStimulus(1, 0, 1, R,    M7,   0, 0, r_b,      "b_no_muldiv");
    applyStimulus(1, 0, 1, BR,   7'd0, 0, 0, br_b,     "b_branch");
    applyStimulus(1, 0, 0, 7'd0, 7'd0, 0, 0, bub,      "b_idle");

    for (int i = 0; i < 20 && due_q.size() > 0; i++) begin
      @(negedge clk);
      #1;
    end
    if (due_q.size() != 0) begin
      n_checks++;
      n_fail++;
      $display("[TB] FAIL drain: %0d expectations pending, required 0", due_q.size());
    end
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
